// File: rtl/lzx_cmp_pkg.sv
// Shared encodings for the lzx 4-bit magnitude comparator.
// Result vectors are ordered {gt, eq, lt}.
package lzx_cmp_pkg;

  localparam int CMP_W = 4;

  localparam logic [2:0] CMP_GT = 3'b100;
  localparam logic [2:0] CMP_EQ = 3'b010;
  localparam logic [2:0] CMP_LT = 3'b001;

endpackage

// File: rtl/lzx_74hc85_core.sv
// Combinational 74HC85-style compare with cascade resolution.
// Operand bits decide MSB first; the cascade inputs only matter on a tie.
module lzx_74hc85_core
  import lzx_cmp_pkg::*;
(
  input  logic [CMP_W-1:0] A,
  input  logic [CMP_W-1:0] B,
  input  logic             IA_g,
  input  logic             IA_e,
  input  logic             IA_l,
  output logic [2:0]       o_res
);

  logic w_dec;
  logic w_gt;

  always_comb begin
    w_dec = 1'b0;
    w_gt  = 1'b0;
    for (int i = CMP_W - 1; i >= 0; i--) begin
      if (!w_dec && (A[i] != B[i])) begin
        w_dec = 1'b1;
        w_gt  = A[i];
      end
    end
  end

  // Tie with IA_e low: both-high gives 000, both-low gives 101.
  always_comb begin
    o_res = CMP_EQ;
    if (w_dec) begin
      o_res = w_gt ? CMP_GT : CMP_LT;
    end else if (IA_e) begin
      o_res = CMP_EQ;
    end else begin
      o_res = {~IA_l, 1'b0, ~IA_g};
    end
  end

endmodule

// File: rtl/lzx_74hc85.sv
// Registered 4-bit magnitude comparator with cascade inputs.
// One cycle of latency; synchronous active-high reset clears all flags.
module lzx_74hc85
  import lzx_cmp_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [CMP_W-1:0] A,
  input  logic [CMP_W-1:0] B,
  input  logic             IA_g,
  input  logic             IA_e,
  input  logic             IA_l,
  output logic             QA_g,
  output logic             QA_e,
  output logic             QA_l
);

  logic [2:0] w_res;
  logic [2:0] r_q;

  lzx_74hc85_core u_core (
    .A     (A),
    .B     (B),
    .IA_g  (IA_g),
    .IA_e  (IA_e),
    .IA_l  (IA_l),
    .o_res (w_res)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= 3'b000;
    end else begin
      r_q <= w_res;
    end
  end

  assign QA_g = r_q[2];
  assign QA_e = r_q[1];
  assign QA_l = r_q[0];

endmodule

// File: tb/tb_lzx_74hc85.sv
// Directed bench for lzx_74hc85: reset, cascade, MSB priority,
// tie resolution, per-cycle latency and mid-stream reset.
module tb_lzx_74hc85;

  logic       clk;
  logic       rst;
  logic [3:0] A;
  logic [3:0] B;
  logic       IA_g;
  logic       IA_e;
  logic       IA_l;
  logic       QA_g;
  logic       QA_e;
  logic       QA_l;

  int n_cmp;
  int n_err;
  logic [2:0] prev;

  lzx_74hc85 dut (
    .clk  (clk),
    .rst  (rst),
    .A    (A),
    .B    (B),
    .IA_g (IA_g),
    .IA_e (IA_e),
    .IA_l (IA_l),
    .QA_g (QA_g),
    .QA_e (QA_e),
    .QA_l (QA_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [2:0] exp);
    logic [2:0] q;
    q = {QA_g, QA_e, QA_l};
    n_cmp++;
    assert (q === exp) else begin
      n_err++;
      $error("FAIL %s got=%b want=%b", tag, q, exp);
    end
  endtask

  // Apply inputs, confirm the output has not moved yet, then
  // check the registered result just after the next edge.
  task automatic step(
    input string      tag,
    input logic       r,
    input logic [3:0] a,
    input logic [3:0] b,
    input logic [2:0] ia,
    input logic [2:0] exp
  );
    rst  = r;
    A    = a;
    B    = b;
    IA_g = ia[2];
    IA_e = ia[1];
    IA_l = ia[0];
    #1;
    chk({tag, "_hold"}, prev);
    @(posedge clk);
    #1;
    chk(tag, exp);
    prev = exp;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst  = 1'b1;
    A    = 4'd5;
    B    = 4'd3;
    IA_g = 1'b0;
    IA_e = 1'b1;
    IA_l = 1'b0;

    @(posedge clk);
    #1;
    chk("rst_c0", 3'b000);
    @(posedge clk);
    #1;
    chk("rst_c1", 3'b000);
    prev = 3'b000;

    step("rel_5v3",   1'b0, 4'd5,     4'd3,     3'b010, 3'b100);

    step("casc_lt",   1'b0, 4'b0000, 4'b1111, 3'b100, 3'b001);
    step("casc_gt",   1'b0, 4'b1111, 4'b0000, 3'b001, 3'b100);

    step("msb_1000",  1'b0, 4'b1000, 4'b0111, 3'b010, 3'b100);
    step("msb_1100",  1'b0, 4'b1100, 4'b1011, 3'b010, 3'b100);
    step("msb_1110",  1'b0, 4'b1110, 4'b1101, 3'b010, 3'b100);
    step("msb_1111",  1'b0, 4'b1111, 4'b1110, 3'b010, 3'b100);
    step("msb_0111",  1'b0, 4'b0111, 4'b1000, 3'b010, 3'b001);
    step("msb_1110l", 1'b0, 4'b1110, 4'b1111, 3'b010, 3'b001);

    step("eq_e",      1'b0, 4'b1010, 4'b1010, 3'b010, 3'b010);
    step("eq_e_all",  1'b0, 4'b1010, 4'b1010, 3'b111, 3'b010);
    step("eq_g",      1'b0, 4'b1010, 4'b1010, 3'b100, 3'b100);
    step("eq_l",      1'b0, 4'b1010, 4'b1010, 3'b001, 3'b001);
    step("eq_gl",     1'b0, 4'b1010, 4'b1010, 3'b101, 3'b000);
    step("eq_none",   1'b0, 4'b1010, 4'b1010, 3'b000, 3'b101);

    step("b2b_0",     1'b0, 4'd3,  4'd9,  3'b010, 3'b001);
    step("b2b_1",     1'b0, 4'd9,  4'd3,  3'b010, 3'b100);
    step("b2b_2",     1'b0, 4'd7,  4'd7,  3'b010, 3'b010);
    step("b2b_3",     1'b0, 4'd0,  4'd1,  3'b100, 3'b001);
    step("b2b_4",     1'b0, 4'd15, 4'd14, 3'b001, 3'b100);

    step("mid_pre",   1'b0, 4'd2,  4'd6,  3'b010, 3'b001);
    step("mid_rst",   1'b1, 4'd12, 4'd4,  3'b010, 3'b000);
    step("mid_post",  1'b0, 4'd12, 4'd4,  3'b010, 3'b100);
    step("mid_next",  1'b0, 4'd0,  4'd0,  3'b000, 3'b101);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
